// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Pipeline sequencer: load-use stalls, branch squash, interrupt entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_D_src_1,
    input  logic [2:0] i_D_src_2,
    input  logic       i_D_use_1,
    input  logic       i_D_use_2,
    input  logic       i_E_mem_read,
    input  logic       i_E_WB,
    input  logic [2:0] i_E_dst_add,
    input  logic       i_branch_taken,
    input  logic       i_int_req,
    output logic       o_pc_write,
    output logic [1:0] o_pc_sel,
    output logic       o_fd_write,
    output logic       o_fd_flush,
    output logic       o_de_flush,
    output logic       o_sp_push,
    output logic       o_int_ack,
    output logic       o_int_busy
);

    localparam logic [1:0] c_SEL_SEQ    = 2'b00;
    localparam logic [1:0] c_SEL_BRANCH = 2'b01;
    localparam logic [1:0] c_SEL_VECTOR = 2'b10;
    localparam logic [2:0] c_DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_PUSH  = 2'd2,
        S_JUMP  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;

    logic w_load_use;
    logic w_accept;

    // All three address bits compared: R0 is an ordinary register here.
    assign w_load_use = i_E_mem_read && i_E_WB &&
                        ((i_D_use_1 && (i_D_src_1 == i_E_dst_add)) ||
                         (i_D_use_2 && (i_D_src_2 == i_E_dst_add)));

    assign w_accept = (r_state == S_RUN) && !i_branch_taken && !w_load_use && i_int_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= c_DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_PUSH;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_PUSH:  r_state <= S_JUMP;
                S_JUMP:  r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_comb begin
        o_pc_write = 1'b0;
        o_pc_sel   = c_SEL_SEQ;
        o_fd_write = 1'b0;
        o_fd_flush = 1'b0;
        o_de_flush = 1'b0;
        o_sp_push  = 1'b0;
        o_int_ack  = 1'b0;
        o_int_busy = 1'b0;
        if (rst) begin
            o_fd_flush = 1'b1;
            o_de_flush = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (i_branch_taken) begin
                        o_pc_write = 1'b1;
                        o_pc_sel   = c_SEL_BRANCH;
                        o_fd_write = 1'b1;
                        o_fd_flush = 1'b1;
                        o_de_flush = 1'b1;
                    end else if (w_load_use) begin
                        o_de_flush = 1'b1;
                    end else if (i_int_req) begin
                        // Fetch slot dropped; PC keeps this address as the return point.
                        o_fd_write = 1'b1;
                        o_fd_flush = 1'b1;
                    end else begin
                        o_pc_write = 1'b1;
                        o_fd_write = 1'b1;
                    end
                end
                S_DRAIN: begin
                    o_int_busy = 1'b1;
                    o_fd_write = 1'b1;
                    o_fd_flush = 1'b1;
                    if (i_branch_taken) begin
                        o_pc_write = 1'b1;
                        o_pc_sel   = c_SEL_BRANCH;
                        o_de_flush = 1'b1;
                    end
                end
                S_PUSH: begin
                    o_int_busy = 1'b1;
                    o_fd_flush = 1'b1;
                    o_sp_push  = 1'b1;
                end
                S_JUMP: begin
                    o_int_busy = 1'b1;
                    o_fd_flush = 1'b1;
                    o_pc_write = 1'b1;
                    o_pc_sel   = c_SEL_VECTOR;
                    o_int_ack  = 1'b1;
                end
                default: begin
                    o_fd_flush = 1'b1;
                    o_de_flush = 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module   : tb_hazard_control_unit
// Purpose  : Directed scoreboard bench for hazard_control_unit (3 parameterisations).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    typedef struct packed {
        logic       pcw;
        logic [1:0] sel;
        logic       fdw;
        logic       care;
        logic       fdf;
        logic       def;
        logic       sp;
        logic       ack;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] D_src_1, D_src_2, E_dst_add;
    logic       D_use_1, D_use_2, E_mem_read, E_WB, branch_taken, int_req;
    logic       int_req_1, int_req_7;

    logic       pc_write, fd_write, fd_flush, de_flush, sp_push, int_ack, int_busy;
    logic [1:0] pc_sel;
    logic       pcw_1, fdw_1, fdf_1, def_1, sp_1, ack_1, busy_1;
    logic [1:0] sel_1;
    logic       pcw_7, fdw_7, fdf_7, def_7, sp_7, ack_7, busy_7;
    logic [1:0] sel_7;

    int checks = 0;
    int errors = 0;
    exp_t  q[$];
    string tq[$];

    always #5 clk = ~clk;

    hazard_control_unit #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .i_D_src_1(D_src_1), .i_D_src_2(D_src_2), .i_D_use_1(D_use_1), .i_D_use_2(D_use_2),
        .i_E_mem_read(E_mem_read), .i_E_WB(E_WB), .i_E_dst_add(E_dst_add),
        .i_branch_taken(branch_taken), .i_int_req(int_req),
        .o_pc_write(pc_write), .o_pc_sel(pc_sel), .o_fd_write(fd_write), .o_fd_flush(fd_flush),
        .o_de_flush(de_flush), .o_sp_push(sp_push), .o_int_ack(int_ack), .o_int_busy(int_busy)
    );

    hazard_control_unit #(.DRAIN_CYCLES(1)) dut_d1 (
        .clk(clk), .rst(rst),
        .i_D_src_1(D_src_1), .i_D_src_2(D_src_2), .i_D_use_1(D_use_1), .i_D_use_2(D_use_2),
        .i_E_mem_read(E_mem_read), .i_E_WB(E_WB), .i_E_dst_add(E_dst_add),
        .i_branch_taken(branch_taken), .i_int_req(int_req_1),
        .o_pc_write(pcw_1), .o_pc_sel(sel_1), .o_fd_write(fdw_1), .o_fd_flush(fdf_1),
        .o_de_flush(def_1), .o_sp_push(sp_1), .o_int_ack(ack_1), .o_int_busy(busy_1)
    );

    hazard_control_unit #(.DRAIN_CYCLES(7)) dut_d7 (
        .clk(clk), .rst(rst),
        .i_D_src_1(D_src_1), .i_D_src_2(D_src_2), .i_D_use_1(D_use_1), .i_D_use_2(D_use_2),
        .i_E_mem_read(E_mem_read), .i_E_WB(E_WB), .i_E_dst_add(E_dst_add),
        .i_branch_taken(branch_taken), .i_int_req(int_req_7),
        .o_pc_write(pcw_7), .o_pc_sel(sel_7), .o_fd_write(fdw_7), .o_fd_flush(fdf_7),
        .o_de_flush(def_7), .o_sp_push(sp_7), .o_int_ack(ack_7), .o_int_busy(busy_7)
    );

    function automatic exp_t mk(input logic pcw, input logic [1:0] sel, input logic fdw,
                                input logic care, input logic fdf, input logic def,
                                input logic sp, input logic ack, input logic busy);
        exp_t e;
        e = {pcw, sel, fdw, care, fdf, def, sp, ack, busy};
        return e;
    endfunction

    // Expected output vectors; care=0 marks fd_write as don't-care (IF/ID flushed anyway).
    exp_t E_RUN, E_BR, E_STALL, E_ACCEPT, E_DRAIN, E_DRAIN_BR, E_PUSH, E_JUMP, E_RST;
    initial begin
        E_RUN      = mk(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        E_BR       = mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        E_STALL    = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        E_ACCEPT   = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        E_DRAIN    = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        E_DRAIN_BR = mk(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        E_PUSH     = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        E_JUMP     = mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        E_RST      = mk(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    task automatic compare_pop();
        exp_t  e;
        exp_t  o;
        string t;
        e = q.pop_front();
        t = tq.pop_front();
        o = {pc_write, pc_sel, (e.care ? fd_write : e.fdw), e.care,
             fd_flush, de_flush, sp_push, int_ack, int_busy};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (pcw,sel,fdw,care,fdf,def,sp,ack,busy)",
                   t, o, e);
        end
    endtask

    task automatic chk_now(input string tag, input exp_t e);
        q.push_back(e);
        tq.push_back(tag);
        @(negedge clk);
        compare_pop();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input exp_t e);
        chk_now(tag, e);
        advance();
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_hazard();
        E_mem_read = 1'b0; E_WB = 1'b0; E_dst_add = 3'd0;
        D_use_1 = 1'b0; D_use_2 = 1'b0; D_src_1 = 3'd0; D_src_2 = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        branch_taken = 1'b0; int_req = 1'b0; int_req_1 = 1'b0; int_req_7 = 1'b0;
        clear_hazard();
        advance();
        step("reset", E_RST);
        rst = 1'b0;
        step("idle_run", E_RUN);

        // Load-use on source 2, then the load has moved on.
        E_mem_read = 1'b1; E_WB = 1'b1; E_dst_add = 3'd3; D_use_2 = 1'b1; D_src_2 = 3'd3;
        step("loaduse_src2", E_STALL);
        E_mem_read = 1'b0; E_WB = 1'b0;
        step("after_stall", E_RUN);
        E_mem_read = 1'b1; E_WB = 1'b1; D_use_2 = 1'b0;
        step("src2_not_used", E_RUN);
        D_use_1 = 1'b1; D_src_1 = 3'd0; E_dst_add = 3'd0;
        step("loaduse_r0_src1", E_STALL);
        E_WB = 1'b0;
        step("load_no_wb", E_RUN);
        E_WB = 1'b1; branch_taken = 1'b1;
        step("branch_over_loaduse", E_BR);
        branch_taken = 1'b0; int_req = 1'b1;
        step("stall_over_int", E_STALL);

        // Interrupt entry, retried after the stall.
        clear_hazard();
        step("int_accept", E_ACCEPT);
        step("drain1", E_DRAIN);
        step("drain2", E_DRAIN);
        step("drain3", E_DRAIN);
        step("push", E_PUSH);
        step("jump", E_JUMP);
        int_req = 1'b0;
        step("post_int_run", E_RUN);

        // Branch resolved during the first drain cycle.
        int_req = 1'b1;
        step("int2_accept", E_ACCEPT);
        branch_taken = 1'b1;
        step("drain_branch", E_DRAIN_BR);
        branch_taken = 1'b0;
        step("int2_drain2", E_DRAIN);
        step("int2_drain3", E_DRAIN);
        step("int2_push", E_PUSH);
        step("int2_jump", E_JUMP);
        int_req = 1'b0;
        step("int2_post_run", E_RUN);

        // Branch beats a simultaneous interrupt request.
        branch_taken = 1'b1; int_req = 1'b1;
        step("branch_over_int", E_BR);
        branch_taken = 1'b0; int_req = 1'b0;
        step("int_not_accepted", E_RUN);

        // Reset asserted while pushing.
        int_req = 1'b1;
        step("int3_accept", E_ACCEPT);
        step("int3_drain1", E_DRAIN);
        step("int3_drain2", E_DRAIN);
        step("int3_drain3", E_DRAIN);
        chk_now("int3_push", E_PUSH);
        rst = 1'b1;
        #1;
        q.push_back(E_RST);
        tq.push_back("reset_in_push");
        compare_pop();
        advance();
        step("reset_held", E_RST);
        rst = 1'b0;
        step("reaccept", E_ACCEPT);
        step("int4_drain1", E_DRAIN);
        step("int4_drain2", E_DRAIN);
        step("int4_drain3", E_DRAIN);
        step("int4_push", E_PUSH);
        step("int4_jump", E_JUMP);
        int_req = 1'b0;
        step("int4_post_run", E_RUN);

        // DRAIN_CYCLES = 1 and 7: push DRAIN_CYCLES+1 cycles after accept, ack one later.
        for (int c = 0; c < 10; c++) begin
            int_req_1 = (c <= 3);
            int_req_7 = 1'b1;
            @(negedge clk);
            chk1($sformatf("d1_sp_push_c%0d", c), sp_1, (c == 2));
            chk1($sformatf("d1_int_ack_c%0d", c), ack_1, (c == 3));
            chk1($sformatf("d7_sp_push_c%0d", c), sp_7, (c == 8));
            chk1($sformatf("d7_int_ack_c%0d", c), ack_7, (c == 9));
            advance();
        end
        int_req_1 = 1'b0;
        int_req_7 = 1'b0;
        @(negedge clk);
        chk1("d7_busy_after", busy_7, 1'b0);
        chk1("d1_busy_after", busy_1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
